// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo frame buffer.
//   - state_t  : capture FSM encoding
//   - DEF_IMG_W / DEF_IMG_H : default frame geometry
//   - ADDR_W   : frame store address width for the default geometry
//   - PIX_W    : grey pixel width
package stereo_pkg;

   localparam int DEF_IMG_W = 20;
   localparam int DEF_IMG_H = 7;
   localparam int ADDR_W    = $clog2(DEF_IMG_W * DEF_IMG_H);
   localparam int PIX_W     = 8;

   typedef enum logic [2:0] {
      ST_WAIT_L = 3'd0,
      ST_CAP_L  = 3'd1,
      ST_WAIT_R = 3'd2,
      ST_CAP_R  = 3'd3,
      ST_READY  = 3'd4
   } state_t;

endpackage

// File: rtl/frame_ram.sv
// Single frame store: synchronous write, asynchronous (combinational) read.
// A read of the address being written in the same cycle returns the old
// contents; the new value is visible after the write edge.
//   clk     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data, combinational from rd_addr
module frame_ram #(
   parameter int DEPTH = 140,
   parameter int AW    = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stereo_frame_buffer.sv
// Captures a left then a right frame from one tagged pixel stream into two
// frame stores, holds them until released, and serves combinational reads.
//   clk, reset           : clock, synchronous active-high reset
//   pix_data/valid/sof   : incoming pixel stream, sof marks pixel (0,0)
//   pix_cam              : pixel source, 0 = left, 1 = right
//   frame_release        : consumer is done with the held pair
//   buffer_href/vref     : read column/row
//   image_sel            : read frame, 0 = left, 1 = right
//   image_data           : selected pixel, 0 when address out of range
//   buffer_ready         : both frames captured and held
//   capture_busy         : a frame is being written
//   seq_error            : sticky camera sequence error
//   frames_done          : completed pair count, wraps
//
// state     | meaning
// ST_WAIT_L | waiting for left start of frame
// ST_CAP_L  | capturing left frame
// ST_WAIT_R | waiting for right start of frame
// ST_CAP_R  | capturing right frame
// ST_READY  | pair held for the consumer
module stereo_frame_buffer
   import stereo_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_valid,
   input  logic             pix_sof,
   input  logic             pix_cam,
   input  logic             frame_release,
   input  logic [9:0]       buffer_href,
   input  logic [9:0]       buffer_vref,
   input  logic             image_sel,
   output logic [PIX_W-1:0] image_data,
   output logic             buffer_ready,
   output logic             capture_busy,
   output logic             seq_error,
   output logic [7:0]       frames_done
);

   localparam int DEPTH = IMG_W * IMG_H;
   localparam int AW    = $clog2(DEPTH);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   state_t           state;
   logic [COL_W-1:0] col, col_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             we_l, we_r;
   logic             restart, wrong_cam, frame_end;
   logic             in_range;
   logic [PIX_W-1:0] rd_l, rd_r;

   // Write decode: which store (if any) takes this pixel, and where.
   always_comb begin
      we_l      = 1'b0;
      we_r      = 1'b0;
      restart   = 1'b0;
      wrong_cam = 1'b0;
      case (state)
         ST_WAIT_L: if (pix_valid && pix_sof && !pix_cam) begin
            we_l    = 1'b1;
            restart = 1'b1;
         end
         ST_CAP_L: if (pix_valid) begin
            if (pix_cam) begin
               wrong_cam = 1'b1;
            end else begin
               we_l    = 1'b1;
               restart = pix_sof;
            end
         end
         ST_WAIT_R: if (pix_valid && pix_sof && pix_cam) begin
            we_r    = 1'b1;
            restart = 1'b1;
         end
         ST_CAP_R: if (pix_valid) begin
            if (!pix_cam) begin
               wrong_cam = 1'b1;
            end else begin
               we_r    = 1'b1;
               restart = pix_sof;
            end
         end
         default: ;
      endcase

      wr_addr = restart ? '0 : AW'(int'(row) * IMG_W + int'(col));

      // A start-of-frame pixel lands at (0,0), so the next one goes to column 1.
      frame_end = 1'b0;
      if (restart) begin
         col_nxt = COL_W'(1);
         row_nxt = '0;
      end else if (col == COL_W'(IMG_W - 1)) begin
         col_nxt = '0;
         if (row == ROW_W'(IMG_H - 1)) begin
            row_nxt   = '0;
            frame_end = 1'b1;
         end else begin
            row_nxt = row + ROW_W'(1);
         end
      end else begin
         col_nxt = col + COL_W'(1);
         row_nxt = row;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_WAIT_L;
         col          <= '0;
         row          <= '0;
         buffer_ready <= 1'b0;
         seq_error    <= 1'b0;
         frames_done  <= '0;
      end else begin
         if (we_l || we_r) begin
            col <= col_nxt;
            row <= row_nxt;
         end
         case (state)
            ST_WAIT_L: if (we_l) state <= ST_CAP_L;
            ST_CAP_L: begin
               if (wrong_cam) begin
                  seq_error <= 1'b1;
                  col       <= '0;
                  row       <= '0;
                  state     <= ST_WAIT_L;
               end else if (we_l && frame_end) begin
                  state <= ST_WAIT_R;
               end
            end
            ST_WAIT_R: if (we_r) state <= ST_CAP_R;
            ST_CAP_R: begin
               // Aborting a right frame also discards the left: the pair
               // must be captured together.
               if (wrong_cam) begin
                  seq_error <= 1'b1;
                  col       <= '0;
                  row       <= '0;
                  state     <= ST_WAIT_L;
               end else if (we_r && frame_end) begin
                  state        <= ST_READY;
                  buffer_ready <= 1'b1;
                  frames_done  <= frames_done + 8'd1;
               end
            end
            ST_READY: begin
               if (frame_release) begin
                  state        <= ST_WAIT_L;
                  buffer_ready <= 1'b0;
               end
            end
            default: state <= ST_WAIT_L;
         endcase
      end
   end

   assign capture_busy = (state == ST_CAP_L) || (state == ST_CAP_R);

   // Read path: range check, then a plain mux of the two store read ports.
   always_comb begin
      in_range = (buffer_href < 10'(IMG_W)) && (buffer_vref < 10'(IMG_H));
      rd_addr  = in_range ? AW'(int'(buffer_vref) * IMG_W + int'(buffer_href)) : '0;
      if (!in_range) begin
         image_data = '0;
      end else begin
         image_data = image_sel ? rd_r : rd_l;
      end
   end

   frame_ram #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_W)) u_ram_l (
      .clk     (clk),
      .we      (we_l),
      .wr_addr (wr_addr),
      .wr_data (pix_data),
      .rd_addr (rd_addr),
      .rd_data (rd_l)
   );

   frame_ram #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_W)) u_ram_r (
      .clk     (clk),
      .we      (we_r),
      .wr_addr (wr_addr),
      .wr_data (pix_data),
      .rd_addr (rd_addr),
      .rd_data (rd_r)
   );

endmodule

// File: tb/tb_stereo_frame_buffer.sv
// Directed self-checking bench for stereo_frame_buffer (20 x 7 frames).
module tb_stereo_frame_buffer;

   logic       clk;
   logic       reset;
   logic [7:0] pix_data;
   logic       pix_valid;
   logic       pix_sof;
   logic       pix_cam;
   logic       frame_release;
   logic [9:0] buffer_href;
   logic [9:0] buffer_vref;
   logic       image_sel;
   logic [7:0] image_data;
   logic       buffer_ready;
   logic       capture_busy;
   logic       seq_error;
   logic [7:0] frames_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] ml [140];
   logic [7:0] mr [140];

   stereo_frame_buffer dut (
      .clk           (clk),
      .reset         (reset),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_sof       (pix_sof),
      .pix_cam       (pix_cam),
      .frame_release (frame_release),
      .buffer_href   (buffer_href),
      .buffer_vref   (buffer_vref),
      .image_sel     (image_sel),
      .image_data    (image_data),
      .buffer_ready  (buffer_ready),
      .capture_busy  (capture_busy),
      .seq_error     (seq_error),
      .frames_done   (frames_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pval(input int kind, input int i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(200 - i);
         2:       return 8'(255 - i);
         default: return 8'(100 + i);
      endcase
   endfunction

   // One pixel per call, accepted at the next rising edge; returns at edge+1.
   task automatic send_pix(input logic cam, input logic sof, input logic [7:0] d);
      pix_cam   = cam;
      pix_sof   = sof;
      pix_data  = d;
      pix_valid = 1'b1;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   // Full frame starting with SOF; optional probe of a read racing the write.
   task automatic send_frame(input logic cam, input int kind, input int probe);
      for (int i = 0; i < 140; i++) begin
         if (i == probe) begin
            pix_cam     = cam;
            pix_sof     = 1'b0;
            pix_data    = pval(kind, i);
            pix_valid   = 1'b1;
            image_sel   = cam;
            buffer_href = 10'(i % 20);
            buffer_vref = 10'(i / 20);
            #1;
            chk("same_cycle_old", {24'd0, image_data}, {24'd0, cam ? mr[i] : ml[i]});
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            chk("next_cycle_new", {24'd0, image_data}, {24'd0, pval(kind, i)});
         end else begin
            send_pix(cam, (i == 0), pval(kind, i));
         end
         if (cam) mr[i] = pval(kind, i);
         else     ml[i] = pval(kind, i);
      end
   endtask

   task automatic read_chk(input string tag, input logic sel, input int h, input int v,
                           input logic [7:0] exp);
      @(negedge clk);
      image_sel   = sel;
      buffer_href = 10'(h);
      buffer_vref = 10'(v);
      #1;
      chk(tag, {24'd0, image_data}, {24'd0, exp});
   endtask

   task automatic release_pair();
      frame_release = 1'b1;
      @(posedge clk);
      #1;
      frame_release = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      pix_data      = 8'h00;
      pix_valid     = 1'b0;
      pix_sof       = 1'b0;
      pix_cam       = 1'b0;
      frame_release = 1'b0;
      buffer_href   = 10'd0;
      buffer_vref   = 10'd0;
      image_sel     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_ready", {31'd0, buffer_ready}, 32'd0);
      chk("rst_busy", {31'd0, capture_busy}, 32'd0);
      chk("rst_seq_err", {31'd0, seq_error}, 32'd0);
      chk("rst_frames", {24'd0, frames_done}, 32'd0);

      // A stray release and a right SOF while waiting for left are ignored.
      release_pair();
      send_pix(1'b1, 1'b1, 8'h11);
      chk("wait_l_ignores_right", {31'd0, capture_busy}, 32'd0);

      // Clean pair.
      send_pix(1'b0, 1'b1, 8'd0);
      ml[0] = 8'd0;
      chk("busy_after_sof", {31'd0, capture_busy}, 32'd1);
      for (int i = 1; i < 140; i++) begin
         send_pix(1'b0, 1'b0, 8'(i));
         ml[i] = 8'(i);
      end
      chk("wait_r_not_busy", {31'd0, capture_busy}, 32'd0);
      chk("wait_r_not_ready", {31'd0, buffer_ready}, 32'd0);
      send_frame(1'b1, 1, -1);
      chk("pair1_ready", {31'd0, buffer_ready}, 32'd1);
      chk("pair1_frames", {24'd0, frames_done}, 32'd1);
      chk("pair1_busy", {31'd0, capture_busy}, 32'd0);
      read_chk("pair1_l_5_3", 1'b0, 5, 3, 8'd65);
      read_chk("pair1_r_5_3", 1'b1, 5, 3, 8'd135);
      read_chk("pair1_r_19_6", 1'b1, 19, 6, 8'd61);
      read_chk("oor_href", 1'b0, 20, 0, 8'h00);
      read_chk("oor_vref", 1'b1, 0, 7, 8'h00);
      read_chk("oor_both", 1'b0, 1023, 1023, 8'h00);

      // Hold: extra pixels of both cameras, with SOFs, are dropped.
      for (int i = 0; i < 50; i++) begin
         send_pix(1'(i % 2), (i % 10 == 0), 8'h55);
      end
      chk("hold_ready", {31'd0, buffer_ready}, 32'd1);
      read_chk("hold_l_5_3", 1'b0, 5, 3, 8'd65);
      read_chk("hold_r_5_3", 1'b1, 5, 3, 8'd135);
      read_chk("hold_l_0_0", 1'b0, 0, 0, 8'd0);
      release_pair();
      chk("release_ready", {31'd0, buffer_ready}, 32'd0);
      chk("release_busy", {31'd0, capture_busy}, 32'd0);

      // Second pair overwrites; probe same-cycle read/write at (4,2).
      send_frame(1'b0, 2, 44);
      send_frame(1'b1, 3, -1);
      chk("pair2_frames", {24'd0, frames_done}, 32'd2);
      read_chk("pair2_l_5_3", 1'b0, 5, 3, 8'd190);
      read_chk("pair2_r_5_3", 1'b1, 5, 3, 8'd165);
      release_pair();

      // Resync inside left capture.
      send_pix(1'b0, 1'b1, 8'd1);
      for (int k = 1; k < 30; k++) send_pix(1'b0, 1'b0, 8'(k + 1));
      send_pix(1'b0, 1'b1, 8'hAA);
      chk("resync_busy", {31'd0, capture_busy}, 32'd1);
      chk("resync_no_err", {31'd0, seq_error}, 32'd0);
      for (int k = 1; k < 140; k++) send_pix(1'b0, 1'b0, 8'(k));
      chk("resync_left_done", {31'd0, capture_busy}, 32'd0);
      send_frame(1'b1, 0, -1);
      chk("resync_ready", {31'd0, buffer_ready}, 32'd1);
      chk("resync_frames", {24'd0, frames_done}, 32'd3);
      read_chk("resync_l_0_0", 1'b0, 0, 0, 8'hAA);
      read_chk("resync_l_5_3", 1'b0, 5, 3, 8'd65);
      read_chk("resync_l_19_6", 1'b0, 19, 6, 8'd139);
      release_pair();

      // Wrong camera during left capture.
      send_pix(1'b0, 1'b1, 8'd0);
      for (int k = 1; k < 10; k++) send_pix(1'b0, 1'b0, 8'(k));
      send_pix(1'b1, 1'b0, 8'hEE);
      chk("wrongcam_err", {31'd0, seq_error}, 32'd1);
      chk("wrongcam_busy", {31'd0, capture_busy}, 32'd0);
      send_frame(1'b0, 0, -1);
      send_frame(1'b1, 1, -1);
      chk("wrongcam_pair_ready", {31'd0, buffer_ready}, 32'd1);
      chk("wrongcam_frames", {24'd0, frames_done}, 32'd4);
      chk("wrongcam_sticky", {31'd0, seq_error}, 32'd1);
      release_pair();

      // Wrong camera during right capture forces left re-capture.
      send_frame(1'b0, 0, -1);
      send_pix(1'b1, 1'b1, 8'd1);
      send_pix(1'b0, 1'b0, 8'd2);
      chk("wrongcam_r_busy", {31'd0, capture_busy}, 32'd0);
      send_pix(1'b1, 1'b1, 8'd3);
      chk("wrongcam_r_to_wait_l", {31'd0, capture_busy}, 32'd0);

      // Reset during right capture.
      send_frame(1'b0, 2, -1);
      send_pix(1'b1, 1'b1, 8'd9);
      for (int k = 1; k < 21; k++) send_pix(1'b1, 1'b0, 8'(k));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_ready", {31'd0, buffer_ready}, 32'd0);
      chk("midrst_busy", {31'd0, capture_busy}, 32'd0);
      chk("midrst_frames", {24'd0, frames_done}, 32'd0);
      chk("midrst_seq_err", {31'd0, seq_error}, 32'd0);
      read_chk("midrst_l_kept", 1'b0, 5, 3, 8'd190);
      send_frame(1'b0, 0, -1);
      send_frame(1'b1, 1, -1);
      chk("post_rst_ready", {31'd0, buffer_ready}, 32'd1);
      chk("post_rst_frames", {24'd0, frames_done}, 32'd1);
      read_chk("post_rst_r_5_3", 1'b1, 5, 3, 8'd135);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
